// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte UART transmitter with input FIFO and internal baud counter.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_fifo #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int FIFO_DEPTH  = 4,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_ODD  = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         data_in,
  input  logic                               data_valid,
  output logic                               ready,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic                               overflow
);
  localparam int CPB = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(CPB);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);

  if (CPB < 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_fifo: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP
`ifdef UART_TX_PARITY_EN
    , ST_PARITY
`endif
  } state_t;

  state_t         state, state_n;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [7:0]     sh;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_cnt;
  logic           push, pop, tick, tx_n;
`ifdef UART_TX_PARITY_EN
  logic           par;
`endif

  assign ready = level != LW'(FIFO_DEPTH);
  assign push  = data_valid && ready;
  assign tick  = cnt == '0;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      ST_IDLE: begin
        pop     = level != '0;
        state_n = pop ? ST_START : ST_IDLE;
      end
      ST_START: begin
        tx_n    = 1'b0;
        state_n = tick ? ST_DATA : ST_START;
      end
      ST_DATA: begin
        tx_n = sh[0];
`ifdef UART_TX_PARITY_EN
        state_n = (tick && bit_cnt == 3'd7) ? ST_PARITY : ST_DATA;
`else
        state_n = (tick && bit_cnt == 3'd7) ? ST_STOP : ST_DATA;
`endif
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_n    = par;
        state_n = tick ? ST_STOP : ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (tick && bit_cnt == 3'(STOP_BITS - 1)) begin
          pop     = level != '0;
          state_n = pop ? ST_START : ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (push) mem[wptr] <= data_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      sh       <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tx       <= tx_n;
      busy     <= state != ST_IDLE;
      wptr     <= push ? wptr + 1'b1 : wptr;
      rptr     <= pop ? rptr + 1'b1 : rptr;
      level    <= level + LW'(push) - LW'(pop);
      overflow <= overflow | (data_valid && !ready);
      if (pop) begin
        sh      <= mem[rptr];
        cnt     <= CW'(CPB - 1);
        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
        par     <= (^mem[rptr]) ^ (PARITY_ODD != 0);
`endif
      end else if (state != ST_IDLE) begin
        // Every bit lasts CPB cycles; bit_cnt restarts whenever the state changes.
        cnt <= tick ? CW'(CPB - 1) : cnt - 1'b1;
        if (tick) begin
          bit_cnt <= (state != state_n) ? 3'd0 : bit_cnt + 3'd1;
          if (state == ST_DATA) sh <= sh >> 1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table, directed sequences and random traffic against a frame-level model.
module tb_uart_tx_fifo;
  localparam int CPB = 10;
  localparam int DEPTH = 4;
  localparam int ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME  = (10 + PB) * CPB;
  localparam int FRAME2 = (11 + PB) * CPB;
  localparam int TMAX = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, data_valid = 1'b0, ready, tx, busy, overflow;
  logic [7:0] data_in = '0;
  logic [2:0] level;
  logic reset2 = 1'b1, data_valid2 = 1'b0, ready2, tx2, busy2, overflow2;
  logic [7:0] data_in2 = '0;
  logic [2:0] level2;

  uart_tx_fifo #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH), .STOP_BITS(1),
                 .PARITY_ODD(ODD)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .ready(ready),
    .tx(tx), .busy(busy), .level(level), .overflow(overflow));

  uart_tx_fifo #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH), .STOP_BITS(2),
                 .PARITY_ODD(ODD)) dut2 (
    .clk(clk), .reset(reset2), .data_in(data_in2), .data_valid(data_valid2), .ready(ready2),
    .tx(tx2), .busy(busy2), .level(level2), .overflow(overflow2));

  int n_chk = 0, n_err = 0;
  int e = 0;
  bit tr_tx [TMAX];
  bit tr_busy [TMAX];
  bit tr_tx2 [TMAX];
  bit tr_busy2 [TMAX];
  int tr_lvl [TMAX];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
    end
  endtask

  // Reference: byte queue plus the time the current frame started; line bits derived from offset.
  logic [7:0] q[$];
  logic [7:0] cur = '0;
  bit m_ovf = 0, m_tx = 1, m_busy = 0;
  int fstart = -100000, busy_until = 0;

  function automatic bit frame_bit(logic [7:0] b, int k);
    int idx = k / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PB == 1 && idx == 9) return (^b) ^ (ODD != 0);
    return 1'b1;
  endfunction

  task automatic model_edge(bit rst, bit dv, logic [7:0] din);
    int k, lvl;
    e++;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_tx = 1; m_busy = 0;
      fstart = -100000; busy_until = 0;
      return;
    end
    k = e - fstart;
    m_busy = k >= 0 && k < FRAME;
    m_tx = m_busy ? frame_bit(cur, k) : 1'b1;
    lvl = q.size();
    if (e >= busy_until && lvl > 0) begin
      cur = q.pop_front();
      fstart = e + 1;
      busy_until = e + FRAME;
    end
    if (dv) begin
      if (lvl < DEPTH) q.push_back(din);
      else m_ovf = 1;
    end
  endtask

  task automatic cycle(bit rst, bit dv, logic [7:0] din);
    reset = rst; data_valid = dv; data_in = din;
    @(posedge clk);
    model_edge(rst, dv, din);
    @(negedge clk);
    if (e < TMAX) begin
      tr_tx[e] = tx; tr_busy[e] = busy; tr_tx2[e] = tx2; tr_busy2[e] = busy2; tr_lvl[e] = int'(level);
    end
    chk("tx", tx, m_tx);
    chk("busy", busy, m_busy);
    chk("level", level, q.size());
    chk("ready", ready, q.size() < DEPTH);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00);
  endtask

  function automatic logic [7:0] dec(int s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = tr_tx[s + (i + 1) * CPB + CPB / 2];
    return r;
  endfunction

  function automatic int count_busy(int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(tr_busy[i]);
    return n;
  endfunction

  typedef struct {
    bit rst; bit dv; logic [7:0] din;
    int lvl; bit rdy; bit ovf; bit tx; bit busy;
  } vec_t;

  initial begin
    vec_t tbl[10];
    int n0, n1, s, mx, z, o, z2, burst;
    tbl[0] = '{1, 0, 8'h00, 0, 1, 0, 1, 0};
    tbl[1] = '{0, 1, 8'h11, 1, 1, 0, 1, 0};
    tbl[2] = '{0, 1, 8'h22, 1, 1, 0, 1, 0};
    tbl[3] = '{0, 1, 8'h33, 2, 1, 0, 0, 1};
    tbl[4] = '{0, 1, 8'h44, 3, 1, 0, 0, 1};
    tbl[5] = '{0, 1, 8'h55, 4, 0, 0, 0, 1};
    tbl[6] = '{0, 1, 8'h66, 4, 0, 1, 0, 1};
    tbl[7] = '{0, 0, 8'h00, 4, 0, 1, 0, 1};
    tbl[8] = '{1, 0, 8'h00, 0, 1, 0, 1, 0};
    tbl[9] = '{0, 0, 8'h00, 0, 1, 0, 1, 0};

    cycle(1, 0, 8'h00);
    reset2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].rst, tbl[i].dv, tbl[i].din);
      chk($sformatf("vec%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("vec%0d_ready", i), ready, tbl[i].rdy);
      chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].ovf);
      chk($sformatf("vec%0d_tx", i), tx, tbl[i].tx);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
    end

    // Single 0xA5 pulse: start bit two edges after the push, busy for one frame.
    n0 = e + 1;
    cycle(0, 1, 8'hA5);
    idle(FRAME + 50);
    chk("t1_pre_start", tr_tx[n0 + 1], 1);
    chk("t1_start", tr_tx[n0 + 2], 0);
    chk("t1_start_end", tr_tx[n0 + 1 + CPB], 0);
    chk("t1_bit0", tr_tx[n0 + 2 + CPB], 1);
    chk("t1_byte", dec(n0 + 2), 8'hA5);
    chk("t1_busy_len", count_busy(n0, e), FRAME);

    // Four-byte burst: one popped at once, so the FIFO peaks at 3; frames abut.
    n0 = e + 1;
    for (int i = 1; i <= 4; i++) cycle(0, 1, 8'(i));
    idle(4 * FRAME + 30);
    mx = 0;
    for (int i = n0; i <= e; i++) if (tr_lvl[i] > mx) mx = tr_lvl[i];
    chk("t2_max_level", mx, 3);
    for (int j = 0; j < 4; j++) chk($sformatf("t2_byte%0d", j), dec(n0 + 2 + j * FRAME), j + 1);
    chk("t2_busy_len", count_busy(n0, e), 4 * FRAME);
    chk("t2_level_end", level, 0);

    // Six-cycle burst: the sixth byte is dropped and overflow sticks.
    n0 = e + 1;
    for (int i = 0; i < 6; i++) cycle(0, 1, 8'hA1 + 8'(i));
    idle(5 * FRAME + 30);
    for (int j = 0; j < 5; j++) chk($sformatf("t3_byte%0d", j), dec(n0 + 2 + j * FRAME), 8'hA1 + j);
    chk("t3_no_extra", tr_busy[n0 + 2 + 5 * FRAME], 0);
    chk("t3_overflow_sticky", overflow, 1);

    // Reset during the 4th data bit aborts the frame and clears everything.
    cycle(1, 0, 8'h00);
    n0 = e + 1;
    for (int i = 0; i < 6; i++) cycle(0, 1, 8'h5A + 8'(i));
    idle(40);
    chk("t4_mid_frame", tr_busy[e], 1);
    cycle(1, 0, 8'h00);
    chk("t4_tx", tx, 1);
    chk("t4_busy", busy, 0);
    chk("t4_level", level, 0);
    chk("t4_overflow", overflow, 0);
    n1 = e + 1;
    cycle(0, 1, 8'h3C);
    idle(FRAME + 20);
    chk("t4_next_byte", dec(n1 + 2), 8'h3C);
    chk("t4_stop", tr_tx[n1 + 1 + FRAME], 1);

`ifdef UART_TX_PARITY_EN
    n0 = e + 1;
    cycle(0, 1, 8'h07);
    idle(FRAME + 20);
    chk("t5_parity", tr_tx[n0 + 2 + 9 * CPB + CPB / 2], (ODD != 0) ? 0 : 1);
    chk("t5_frame_len", count_busy(n0, e), FRAME);
`endif

    // Two stop bits: 0x00 then 0xFF back-to-back on the second instance.
    n0 = e + 1;
    data_valid2 = 1'b1; data_in2 = 8'h00;
    cycle(0, 0, 8'h00);
    data_in2 = 8'hFF;
    cycle(0, 0, 8'h00);
    data_valid2 = 1'b0;
    idle(2 * FRAME2 + 40);
    s = n0 + 2;
    z = 0; o = 0; z2 = 0;
    while (s < e && tr_tx2[s] == 0 && z < 400) begin z++; s++; end
    while (s < e && tr_tx2[s] == 1 && o < 400) begin o++; s++; end
    while (s < e && tr_tx2[s] == 0 && z2 < 400) begin z2++; s++; end
    chk("t6_first_start", tr_tx2[n0 + 2], 0);
    chk("t6_low_run", z, (9 + PB * ((ODD == 0) ? 1 : 0)) * CPB);
    chk("t6_stop_gap", o, (2 + PB * ((ODD != 0) ? 1 : 0)) * CPB);
    chk("t6_next_start", z2, CPB);
    o = 0;
    for (int i = n0; i <= e; i++) o += int'(tr_busy2[i]);
    chk("t6_busy_len", o, 2 * FRAME2);

    // Random traffic with bursts and occasional resets, checked each cycle by the model.
    burst = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom % 250 == 0) burst = $urandom_range(1, 8);
      cycle(($urandom % 2500) == 0, burst > 0 || ($urandom % 100) < 2, 8'($urandom));
      if (burst > 0) burst--;
    end
    idle(DEPTH * FRAME + 2 * FRAME);
    chk("rand_drain_level", level, 0);
    chk("rand_drain_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
